// File: rtl/agc_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | agc_ctrl_pkg : shared types and constants for the AGC key ctrl   |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package agc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT     = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_DEFAULTS = 2'd3
  } state_e;

  localparam int unsigned N_SRC     = 3;
  localparam int unsigned SRC_KEY   = 0;
  localparam int unsigned SRC_RIGHT = 1;
  localparam int unsigned SRC_LEFT  = 2;

  localparam logic [1:0] ADDR_TARGET   = 2'd0;
  localparam logic [1:0] ADDR_ATTACK   = 2'd1;
  localparam logic [1:0] ADDR_RELEASE  = 2'd2;
  localparam logic [1:0] ADDR_MAX_GAIN = 2'd3;

  localparam logic [7:0] DEF_TARGET   = 8'hC0;
  localparam logic [7:0] MAX_TARGET   = 8'd255;
  localparam logic [7:0] DEF_ATTACK   = 8'd4;
  localparam logic [7:0] MAX_ATTACK   = 8'd15;
  localparam logic [7:0] DEF_RELEASE  = 8'd8;
  localparam logic [7:0] MAX_RELEASE  = 8'd15;
  localparam logic [7:0] DEF_MAX_GAIN = 8'd24;
  localparam logic [7:0] MAX_MAX_GAIN = 8'd48;

  function automatic logic [7:0] param_default(input logic [1:0] addr);
    case (addr)
      ADDR_TARGET:  param_default = DEF_TARGET;
      ADDR_ATTACK:  param_default = DEF_ATTACK;
      ADDR_RELEASE: param_default = DEF_RELEASE;
      default:      param_default = DEF_MAX_GAIN;
    endcase
  endfunction

  function automatic logic [7:0] param_max(input logic [1:0] addr);
    case (addr)
      ADDR_TARGET:  param_max = MAX_TARGET;
      ADDR_ATTACK:  param_max = MAX_ATTACK;
      ADDR_RELEASE: param_max = MAX_RELEASE;
      default:      param_max = MAX_MAX_GAIN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_key_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | agc_key_ctrl_if : valid/ready config write bus to the AGC core   |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
interface agc_key_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/key_evt_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_evt_sync : sync, rising-edge detect and pending flags        |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module key_evt_sync
  import agc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] key_irq,
  input  logic [2:0]       key_value,
  input  logic [N_SRC-1:0] serve,
  output logic [N_SRC-1:0] pend,
  output logic [2:0]       key_code
);
  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q, pend_q, pend_d, evt;
  logic [2:0]       code_q, code_d;

  // An edge that lands while its flag is still set (even on the serve cycle) is dropped.
  always_comb begin
    evt    = sync2_q & ~prev_q;
    pend_d = (pend_q & ~serve) | (evt & ~pend_q);
    code_d = (evt[SRC_KEY] && !pend_q[SRC_KEY]) ? key_value : code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      code_q  <= '0;
    end else begin
      sync1_q <= key_irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

  assign pend     = pend_q;
  assign key_code = code_q;
endmodule
`default_nettype wire

// File: rtl/agc_key_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | agc_key_ctrl : key/encoder menu that edits and writes AGC params |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module agc_key_ctrl
  import agc_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_MS = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       key_value,
  input  logic [N_SRC-1:0] key_irq,
  agc_key_ctrl_if.master   cfg,
  output logic [1:0]       menu_sel,
  output logic             edit_mode,
  output logic             bypass
);
  localparam int unsigned TIMEOUT_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       menu_q, menu_d, addr_q, addr_d, menu_nxt;
  logic [7:0]       shadow_q, shadow_d, data_q, data_d;
  logic [3:0][7:0]  regs_q, regs_d;
  logic             bypass_q, bypass_d, valid_q, valid_d, ret_edit_q, ret_edit_d, edit_q;
  logic [31:0]      timer_q, timer_d;
  logic [N_SRC-1:0] pend, serve;
  logic [2:0]       key_code;

  key_evt_sync u_evt (
    .clk       (clk),
    .rst       (rst),
    .key_irq   (key_irq),
    .key_value (key_value),
    .serve     (serve),
    .pend      (pend),
    .key_code  (key_code)
  );

  assign menu_nxt = menu_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    menu_d     = menu_q;
    shadow_d   = shadow_q;
    regs_d     = regs_q;
    bypass_d   = bypass_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ret_edit_d = ret_edit_q;
    timer_d    = '0;
    serve      = '0;
    if (state_q == ST_IDLE || state_q == ST_EDIT) begin
      if (pend[SRC_KEY])        serve[SRC_KEY]   = 1'b1;
      else if (pend[SRC_RIGHT]) serve[SRC_RIGHT] = 1'b1;
      else if (pend[SRC_LEFT])  serve[SRC_LEFT]  = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (serve[SRC_RIGHT])     menu_d = menu_q + 2'd1;
        else if (serve[SRC_LEFT]) menu_d = menu_q - 2'd1;
        else if (serve[SRC_KEY]) begin
          case (key_code)
            3'd1: begin
              shadow_d = regs_q[menu_q];
              state_d  = ST_EDIT;
            end
            3'd4:    bypass_d = ~bypass_q;
            3'd5:    state_d  = ST_DEFAULTS;
            default: ;
          endcase
        end
      end
      ST_EDIT: begin
        timer_d = timer_q + 32'd1;
        if (serve[SRC_RIGHT]) begin
          timer_d = '0;
          if (shadow_q != param_max(menu_q)) shadow_d = shadow_q + 8'd1;
        end else if (serve[SRC_LEFT]) begin
          timer_d = '0;
          if (shadow_q != 8'd0) shadow_d = shadow_q - 8'd1;
        end else if (serve[SRC_KEY]) begin
          timer_d = '0;
          case (key_code)
            3'd1, 3'd2: begin
              valid_d    = 1'b1;
              addr_d     = menu_q;
              data_d     = shadow_q;
              ret_edit_d = (key_code == 3'd1);
              state_d    = ST_COMMIT;
            end
            3'd3:    state_d = ST_IDLE;
            default: ;
          endcase
        end else if (timer_q >= TIMEOUT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (cfg.cfg_ready) begin
          regs_d[addr_q] = data_q;
          valid_d        = 1'b0;
          if (ret_edit_q) begin
            menu_d   = menu_nxt;
            shadow_d = regs_q[menu_nxt];
            state_d  = ST_EDIT;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        // DEFAULTS: first cycle raises the address-0 write, then walk 0..3.
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = ADDR_TARGET;
          data_d  = param_default(ADDR_TARGET);
        end else if (cfg.cfg_ready) begin
          regs_d[addr_q] = data_q;
          if (addr_q == ADDR_MAX_GAIN) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + 2'd1;
            data_d = param_default(addr_q + 2'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DEFAULTS;
      menu_q     <= '0;
      shadow_q   <= '0;
      regs_q     <= {DEF_MAX_GAIN, DEF_RELEASE, DEF_ATTACK, DEF_TARGET};
      bypass_q   <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ret_edit_q <= 1'b0;
      timer_q    <= '0;
      edit_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      menu_q     <= menu_d;
      shadow_q   <= shadow_d;
      regs_q     <= regs_d;
      bypass_q   <= bypass_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ret_edit_q <= ret_edit_d;
      timer_q    <= timer_d;
      edit_q     <= (state_d == ST_EDIT);
    end
  end

  assign cfg.cfg_valid = valid_q;
  assign cfg.cfg_addr  = addr_q;
  assign cfg.cfg_data  = data_q;
  assign menu_sel      = menu_q;
  assign edit_mode     = edit_q;
  assign bypass        = bypass_q;
endmodule
`default_nettype wire

// File: tb/tb_agc_key_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_agc_key_ctrl : directed + random bench with reference model   |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module tb_agc_key_ctrl;
  localparam int unsigned T_CLK_HZ     = 100000;
  localparam int unsigned T_TIMEOUT_MS = 1;
  localparam int          TIMEOUT_CYC  = T_CLK_HZ / 1000 * T_TIMEOUT_MS;

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_value = '0;
  logic [2:0] key_irq = '0;
  logic [1:0] menu_sel;
  logic       edit_mode, bypass;
  int         ready_mode = 1;
  int         tests = 0, fails = 0, cyc = 0;

  agc_key_ctrl_if cfg ();

  agc_key_ctrl #(.CLK_HZ(T_CLK_HZ), .TIMEOUT_MS(T_TIMEOUT_MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_value (key_value),
    .key_irq   (key_irq),
    .cfg       (cfg),
    .menu_sel  (menu_sel),
    .edit_mode (edit_mode),
    .bypass    (bypass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (ready_mode)
      0:       cfg.cfg_ready = 1'b0;
      1:       cfg.cfg_ready = 1'b1;
      default: cfg.cfg_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // reference model state
  int  def_v [4] = '{192, 4, 8, 24};
  int  max_v [4] = '{255, 15, 15, 48};
  int  m_reg [4];
  int  m_menu, m_shadow, m_bypass, m_edit;
  wr_t act_q[$];
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // bus monitor: records accepted writes and checks pending requests hold
  logic       pv = 1'b0;
  logic [1:0] pa;
  logic [7:0] pd;
  always @(negedge clk) begin
    wr_t w;
    #2;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        check("hold_valid", cfg.cfg_valid, 1);
        check("hold_addr", cfg.cfg_addr, pa);
        check("hold_data", cfg.cfg_data, pd);
      end
      if (cfg.cfg_valid === 1'b1 && cfg.cfg_ready === 1'b1) begin
        w.addr = int'(cfg.cfg_addr);
        w.data = int'(cfg.cfg_data);
        w.cyc  = cyc;
        act_q.push_back(w);
      end
      pv = (cfg.cfg_valid === 1'b1) && (cfg.cfg_ready !== 1'b1);
      pa = cfg.cfg_addr;
      pd = cfg.cfg_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = 0;
    exp_q.push_back(w);
    m_reg[a] = d;
  endtask

  task automatic model_defaults();
    for (int a = 0; a < 4; a++) model_write(a, def_v[a]);
  endtask

  task automatic model_reset();
    for (int a = 0; a < 4; a++) m_reg[a] = def_v[a];
    m_menu = 0; m_shadow = 0; m_bypass = 0; m_edit = 0;
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic model_event(input int src, input int code);
    if (m_edit == 0) begin
      if (src == 1)      m_menu = (m_menu + 1) % 4;
      else if (src == 2) m_menu = (m_menu + 3) % 4;
      else if (code == 1) begin m_shadow = m_reg[m_menu]; m_edit = 1; end
      else if (code == 4) m_bypass = 1 - m_bypass;
      else if (code == 5) model_defaults();
    end else begin
      if (src == 1)      m_shadow = (m_shadow < max_v[m_menu]) ? m_shadow + 1 : m_shadow;
      else if (src == 2) m_shadow = (m_shadow > 0) ? m_shadow - 1 : 0;
      else if (code == 1) begin
        model_write(m_menu, m_shadow);
        m_menu   = (m_menu + 1) % 4;
        m_shadow = m_reg[m_menu];
      end
      else if (code == 2) begin model_write(m_menu, m_shadow); m_edit = 0; end
      else if (code == 3) m_edit = 0;
    end
  endtask

  task automatic pulse(input int src, input int code);
    if (src == 0) key_value = 3'(code);
    key_irq[src] = 1'b1;
    tick(4);
    key_irq[src] = 1'b0;
    tick(4);
  endtask

  task automatic settle();
    int n = 0;
    tick(3);
    while (cfg.cfg_valid === 1'b1 && n < 400) begin tick(1); n++; end
    check("handshake_done", cfg.cfg_valid, 0);
    tick(3);
  endtask

  task automatic verify(input string tag);
    int n;
    check({tag, "_menu"}, menu_sel, m_menu);
    check({tag, "_edit"}, edit_mode, m_edit);
    check({tag, "_bypass"}, bypass, m_bypass);
    check({tag, "_wr_cnt"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr_addr"}, act_q[i].addr, exp_q[i].addr);
      check({tag, "_wr_data"}, act_q[i].data, exp_q[i].data);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic step(input string tag, input int src, input int code);
    pulse(src, code);
    model_event(src, code);
    settle();
    verify(tag);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cfg.cfg_valid !== 1'b1 && n < 100) begin tick(1); n++; end
    check("valid_rise", cfg.cfg_valid, 1);
  endtask

  initial begin
    // reset values
    rst = 1'b1;
    model_reset();
    tick(3);
    check("rst_valid", cfg.cfg_valid, 0);
    check("rst_addr", cfg.cfg_addr, 0);
    check("rst_data", cfg.cfg_data, 0);
    check("rst_menu", menu_sel, 0);
    check("rst_edit", edit_mode, 0);
    check("rst_bypass", bypass, 0);

    // defaults written back-to-back after release
    rst = 1'b0;
    model_defaults();
    settle();
    if (act_q.size() == 4) check("dflt_consecutive", act_q[3].cyc - act_q[0].cyc, 3);
    verify("dflt");

    // menu navigation with wrap both ways
    step("left1", 2, 0);
    step("left2", 2, 0);
    step("left3", 2, 0);
    step("right_a", 1, 0);
    step("right_b", 1, 0);
    step("right_wrap", 1, 0);
    step("left_wrap", 2, 0);

    // max_gain edit saturating at 48, with a stalled acceptance
    step("mg_edit", 0, 1);
    for (int i = 0; i < 30; i++) step("mg_up", 1, 0);
    ready_mode = 0;
    pulse(0, 2);
    model_event(0, 2);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", cfg.cfg_valid, 1);
      check("stall_addr", cfg.cfg_addr, 3);
      check("stall_data", cfg.cfg_data, 48);
      tick(1);
    end
    ready_mode = 1;
    settle();
    verify("mg_commit");

    // discard an edit, then prove target kept its value
    step("to_target", 1, 0);
    step("tg_edit", 0, 1);
    for (int i = 0; i < 5; i++) step("tg_up", 1, 0);
    step("tg_discard", 0, 3);
    step("tg_edit2", 0, 1);
    step("tg_commit", 0, 2);

    // key and right arriving together: key wins, right follows
    key_value = 3'd1;
    key_irq   = 3'b011;
    tick(4);
    key_irq   = 3'b000;
    tick(4);
    model_event(0, 1);
    model_event(1, 0);
    settle();
    verify("simul");
    step("simul_commit", 0, 2);

    // events held during DEFAULTS; second right edge while pending is lost
    ready_mode = 0;
    pulse(0, 5);
    model_event(0, 5);
    pulse(1, 0);
    pulse(1, 0);
    model_event(1, 0);
    ready_mode = 1;
    settle();
    verify("drop");

    // random traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int src, code;
      src  = int'($urandom_range(0, 2));
      code = (src == 0) ? int'($urandom_range(0, 7)) : 0;
      step("rand", src, code);
    end
    ready_mode = 1;
    if (m_edit != 0) step("rand_exit", 0, 3);

    // inactivity timeout
    step("to_edit", 0, 1);
    tick(TIMEOUT_CYC - 30);
    check("to_still_edit", edit_mode, 1);
    tick(60);
    m_edit = 0;
    verify("timeout");

    // reset during a COMMIT handshake
    step("rc_edit", 0, 1);
    ready_mode = 0;
    pulse(0, 2);
    wait_valid();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drops_valid", cfg.cfg_valid, 0);
    tick(2);
    model_reset();
    ready_mode = 1;
    rst = 1'b0;
    model_defaults();
    settle();
    verify("rerun_dflt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/agc_key_ctrl.md
AGC_KEY_CTRL -- requirements
Module: agc_key_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 5000, meaning edit-mode inactivity timeout in ms.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_value  in  3  debounced key code; only 1..5 are meaningful.
REQ-006 SHALL have port key_irq  in  3  bit0 key-press level, bit1 encoder-right level, bit2 encoder-left level; slow-domain, asynchronous to clk.
REQ-007 SHALL have port cfg_valid  out  1  config write request to AGC core.
REQ-008 SHALL have port cfg_ready  in  1  AGC core accepts the write.
REQ-009 SHALL have port cfg_addr  out  2  0=target, 1=attack, 2=release, 3=max_gain.
REQ-010 SHALL have port cfg_data  out  8  parameter value, zero-extended.
REQ-011 SHALL have port menu_sel  out  2  currently selected parameter.
REQ-012 SHALL have port edit_mode  out  1  high while in EDIT.
REQ-013 SHALL have port bypass  out  1  AGC bypass flag.

Function
REQ-014 SHALL pass each key_irq bit through a 2-flop synchronizer; a rising edge of a synchronized bit SHALL be one event; key_value SHALL be sampled with the key event.
REQ-015 SHALL hold one pending flag per source; a new event on a source whose flag is already set SHALL be dropped.
REQ-016 SHALL serve at most one pending event per cycle, in priority key > right > left, and only in IDLE or EDIT.
REQ-017 SHALL keep committed registers with default/max values: target 0xC0/255, attack 4/15, release 8/15, max_gain 24/48; EDIT SHALL operate on a shadow copy.
REQ-018 States: IDLE, EDIT, COMMIT, DEFAULTS.
REQ-019 IDLE: right/left SHALL move menu_sel +1/-1 with wrap 3->0 and 0->3; key 1 SHALL copy the selected register to the shadow and go to EDIT; key 4 SHALL toggle bypass; key 5 SHALL go to DEFAULTS; other keys SHALL be ignored.
REQ-020 EDIT: right/left SHALL step the shadow +1/-1, saturating at 0 and at the parameter max; key 2 SHALL go to COMMIT; key 3 SHALL discard the shadow and go to IDLE; key 1 SHALL commit the current shadow first, then select the next parameter (with wrap) and stay in EDIT; other keys SHALL be ignored.
REQ-021 SHALL keep an EDIT inactivity counter that is cleared on every served event; when it reaches CLK_HZ/1000*TIMEOUT_MS cycles, the block SHALL behave as on key 3.
REQ-022 COMMIT: SHALL assert cfg_valid with cfg_addr=menu_sel and cfg_data=shadow, held stable until the cycle cfg_ready=1; that cycle SHALL update the committed register and go to IDLE, or return to EDIT for the key-1 case.
REQ-023 DEFAULTS: SHALL load the defaults and write addresses 0,1,2,3 in order, each with the REQ-022 handshake, then go to IDLE; bypass SHALL be unchanged.
REQ-024 cfg_valid SHALL never deassert before acceptance; events arriving during COMMIT/DEFAULTS SHALL remain pending.
REQ-025 edit_mode SHALL equal (state==EDIT) registered, with no combinational path from any input.

Reset
REQ-026 While rst is high: cfg_valid=0, cfg_addr=0, cfg_data=0, menu_sel=0, edit_mode=0, bypass=0, committed registers at default, pending flags and synchronizers cleared.
REQ-027 After rst falls, the block SHALL enter DEFAULTS so the AGC core is initialized; a reset during a handshake SHALL drop cfg_valid immediately.

Structure
REQ-028 Package agc_ctrl_pkg SHALL hold the state enum, the cfg address constants, and the per-parameter default and max constants.
REQ-029 Sub-module key_evt_sync SHALL hold the synchronizers, edge detection and pending flags for the three sources.

Verification
REQ-030 Reset release with cfg_ready tied 1 -> four writes (0,0xC0),(1,4),(2,8),(3,24) on consecutive cycles, then IDLE.
REQ-031 IDLE: 3 left steps from menu_sel=0 -> menu_sel 3,2,1.
REQ-032 Select max_gain, key 1, 30 right steps, key 2 -> one write (3,48) (saturated); cfg_ready held low 10 cycles -> cfg_valid and data stable throughout.
REQ-033 EDIT target, 5 right steps, key 3 -> no cfg write, target remains 0xC0, edit_mode=0.
REQ-034 Key press and right edge synchronized in the same cycle -> key served first, right served next cycle; a second right edge while pending -> dropped.
REQ-035 EDIT with no events for the timeout (TIMEOUT_MS reduced in sim) -> IDLE, no write; rst asserted mid-COMMIT -> cfg_valid 0 at once, DEFAULTS rerun.
